// File: rtl/keyboard_note_sequencer.sv
// rtl/keyboard_note_sequencer.sv - bus-programmable melody sequencer with keyboard tone override
`timescale 1ns/1ps
module keyboard_note_sequencer #(
  parameter int CLK_HZ = 25_000_000,
  parameter int DEPTH  = 16,
  parameter int GAP_MS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] d_in,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic        rd,
  input  logic        wr,
  output logic [31:0] d_out,
  input  logic [3:0]  buttons_in,
  output logic [31:0] freq_out,
  output logic        playing
);

  localparam int              IW        = $clog2(DEPTH);
  localparam logic [IW-1:0]   LAST_IDX  = IW'(DEPTH - 1);
  localparam logic [31:0]     TICK_LAST = 32'(CLK_HZ / 1000 - 1);
  localparam logic [15:0]     GAP_LD    = 16'(GAP_MS);
  localparam logic [31:0]     NOTE_C4   = 32'(CLK_HZ / (2 * 262));
  localparam logic [31:0]     NOTE_D4   = 32'(CLK_HZ / (2 * 294));
  localparam logic [31:0]     NOTE_E4   = 32'(CLK_HZ / (2 * 330));
  localparam logic [31:0]     NOTE_F4   = 32'(CLK_HZ / (2 * 349));

  localparam logic [4:0] A_CTRL   = 5'h00;
  localparam logic [4:0] A_WIDX   = 5'h04;
  localparam logic [4:0] A_NOTE   = 5'h08;
  localparam logic [4:0] A_STATUS = 5'h0C;

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  state_t        state_q, state_d;
  logic          loop_q, loop_d;
  logic [IW-1:0] widx_q, widx_d;
  logic [IW-1:0] cur_idx_q, cur_idx_d;
  logic [19:0]   cur_freq_q, cur_freq_d;
  logic [11:0]   dur_cnt_q, dur_cnt_d;
  logic [15:0]   gap_cnt_q, gap_cnt_d;
  logic [31:0]   presc_q, presc_d;
  logic [31:0]   d_out_q, d_out_d;
  logic [31:0]   freq_q, freq_d;

  logic [31:0]   mem [DEPTH];

  logic [4:0]    a;
  logic          wr_en, rd_en;
  logic          ctrl_wr, widx_wr, note_wr;
  logic          start_req, stop_req;
  logic          btn_any, cnt_run, tick, adv;
  logic [31:0]   entry;
  logic [31:0]   rdata;
  logic          unused_addr;

  assign a           = addr[4:0];
  assign unused_addr = ^addr[31:5];
  assign wr_en       = cs & wr;
  assign rd_en       = cs & rd;
  assign ctrl_wr     = wr_en && (a == A_CTRL);
  assign widx_wr     = wr_en && (a == A_WIDX);
  assign note_wr     = wr_en && (a == A_NOTE);
  assign start_req   = ctrl_wr & d_in[0];
  assign stop_req    = ctrl_wr & d_in[1];

  assign btn_any     = |buttons_in;
  // Counters only run in PLAY/GAP and freeze while a key is held so playback resumes in place.
  assign cnt_run     = ((state_q == PLAY) || (state_q == GAP)) && !btn_any;
  assign tick        = cnt_run && (presc_q == TICK_LAST);
  assign entry       = mem[cur_idx_q];

  assign playing     = (state_q != IDLE);
  assign d_out       = d_out_q;
  assign freq_out    = freq_q;

  // Note memory: written from the bus only, never reset.
  always_ff @(posedge clk) begin
    if (note_wr) begin
      mem[widx_q] <= d_in;
    end
  end

  // Control register and note write pointer.
  always_comb begin
    loop_d = loop_q;
    widx_d = widx_q;
    if (ctrl_wr) begin
      loop_d = d_in[2];
    end
    if (widx_wr) begin
      widx_d = d_in[IW-1:0];
    end else if (note_wr) begin
      widx_d = (widx_q == LAST_IDX) ? '0 : widx_q + IW'(1);
    end
  end

  // Sequencer next state: list walk, ms prescaler and duration/gap counting.
  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    cur_freq_d = cur_freq_q;
    dur_cnt_d  = dur_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    presc_d    = presc_q;
    adv        = 1'b0;

    if (cnt_run) begin
      presc_d = tick ? 32'd0 : presc_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        presc_d = 32'd0;
      end
      LOAD: begin
        // Holding the prescaler at zero here clears it on every entry to PLAY.
        presc_d = 32'd0;
        if (entry[31:20] == 12'd0) begin
          // Only wrap on a marker past entry 0, otherwise an empty list would spin forever.
          if (loop_q && (cur_idx_q != '0)) begin
            cur_idx_d = '0;
            state_d   = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cur_freq_d = entry[19:0];
          dur_cnt_d  = entry[31:20];
          state_d    = PLAY;
        end
      end
      PLAY: begin
        if (tick) begin
          if (dur_cnt_q <= 12'd1) begin
            if (GAP_MS == 0) begin
              adv = 1'b1;
            end else begin
              gap_cnt_d = GAP_LD;
              state_d   = GAP;
            end
          end else begin
            dur_cnt_d = dur_cnt_q - 12'd1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (gap_cnt_q <= 16'd1) begin
            adv = 1'b1;
          end else begin
            gap_cnt_d = gap_cnt_q - 16'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (adv) begin
      if (cur_idx_q == LAST_IDX) begin
        if (loop_q) begin
          cur_idx_d = '0;
          state_d   = LOAD;
        end else begin
          state_d = IDLE;
        end
      end else begin
        cur_idx_d = cur_idx_q + IW'(1);
        state_d   = LOAD;
      end
    end

    if (start_req) begin
      cur_idx_d = '0;
      state_d   = LOAD;
    end
    if (stop_req) begin
      state_d = IDLE;
    end
  end

  // Tone arbitration and bus read mux.
  always_comb begin
    freq_d = 32'd0;
    if (buttons_in[0]) begin
      freq_d = NOTE_C4;
    end else if (buttons_in[1]) begin
      freq_d = NOTE_D4;
    end else if (buttons_in[2]) begin
      freq_d = NOTE_E4;
    end else if (buttons_in[3]) begin
      freq_d = NOTE_F4;
    end else if (state_q == PLAY) begin
      freq_d = {12'd0, cur_freq_q};
    end

    rdata = 32'd0;
    case (a)
      A_CTRL:   rdata = {29'd0, loop_q, 1'b0, playing};
      A_WIDX:   rdata = {28'd0, 4'(widx_q)};
      A_NOTE:   rdata = mem[widx_q];
      A_STATUS: rdata = {20'd0, 4'(cur_idx_q), 3'd0, playing, buttons_in};
      default:  rdata = 32'd0;
    endcase
    d_out_d = rd_en ? rdata : 32'd0;
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      loop_q     <= 1'b0;
      widx_q     <= '0;
      cur_idx_q  <= '0;
      cur_freq_q <= 20'd0;
      dur_cnt_q  <= 12'd0;
      gap_cnt_q  <= 16'd0;
      presc_q    <= 32'd0;
      d_out_q    <= 32'd0;
      freq_q     <= 32'd0;
    end else begin
      state_q    <= state_d;
      loop_q     <= loop_d;
      widx_q     <= widx_d;
      cur_idx_q  <= cur_idx_d;
      cur_freq_q <= cur_freq_d;
      dur_cnt_q  <= dur_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      presc_q    <= presc_d;
      d_out_q    <= d_out_d;
      freq_q     <= freq_d;
    end
  end

endmodule

// File: tb/tb_keyboard_note_sequencer.sv
// tb/tb_keyboard_note_sequencer.sv - directed self-checking bench for keyboard_note_sequencer
`timescale 1ns/1ps
module tb_keyboard_note_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] d_in;
  logic        cs;
  logic [31:0] addr;
  logic        rd;
  logic        wr;
  logic [31:0] d_out;
  logic [3:0]  buttons_in;
  logic [31:0] freq_out;
  logic        playing;

  int n_pass  = 0;
  int n_total = 0;

  keyboard_note_sequencer #(
    .CLK_HZ(1_000_000),
    .DEPTH (16),
    .GAP_MS(1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d_in      (d_in),
    .cs        (cs),
    .addr      (addr),
    .rd        (rd),
    .wr        (wr),
    .d_out     (d_out),
    .buttons_in(buttons_in),
    .freq_out  (freq_out),
    .playing   (playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk);
    #1;
    cs = 1'b0; rd = 1'b0;
    d = d_out;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] d;
    int k;
    reset = 1'b1; cs = 1'b0; rd = 1'b0; wr = 1'b0; addr = 32'd0; d_in = 32'd0; buttons_in = 4'd0;
    wait_cyc(3);
    check("rst_freq", freq_out, 32'd0);
    check("rst_playing", {31'd0, playing}, 32'd0);
    check("rst_dout", d_out, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    rd_reg(32'h00, d);  check("rd_ctrl_rst", d, 32'd0);
    wait_cyc(1);        check("rd_dout_returns_0", d_out, 32'd0);
    rd_reg(32'h0C, d);  check("rd_status_rst", d, 32'd0);
    rd_reg(32'h04, d);  check("rd_widx_rst", d, 32'd0);

    @(negedge clk); buttons_in = 4'b0100; @(posedge clk); #1;
    check("btn_e4", freq_out, 32'd1515);
    @(negedge clk); buttons_in = 4'b1001; @(posedge clk); #1;
    check("btn_c4_prio", freq_out, 32'd1908);
    rd_reg(32'h0C, d);  check("status_buttons", d, 32'h9);
    @(negedge clk); buttons_in = 4'b1000; @(posedge clk); #1;
    check("btn_f4", freq_out, 32'd1432);
    @(negedge clk); buttons_in = 4'b0000; @(posedge clk); #1;
    check("btn_release", freq_out, 32'd0);

    wr_reg(32'h04, 32'd0);
    wr_reg(32'h08, 32'h0030_03E8);
    wr_reg(32'h08, 32'h0000_0000);
    rd_reg(32'h04, d);  check("widx_after_2", d, 32'd2);
    wr_reg(32'h04, 32'd0);
    rd_reg(32'h08, d);  check("note_readback", d, 32'h0030_03E8);
    wr_reg(32'h00, 32'd1);
    check("one_playing_rise", {31'd0, playing}, 32'd1);
    check("one_freq_load", freq_out, 32'd0);
    wait_cyc(1);    check("one_freq_e1", freq_out, 32'd0);
    wait_cyc(1);    check("one_freq_e2", freq_out, 32'd1000);
    wait_cyc(2999); check("one_freq_last", freq_out, 32'd1000);
    wait_cyc(1);    check("one_freq_gap", freq_out, 32'd0);
    check("one_playing_gap", {31'd0, playing}, 32'd1);
    wait_cyc(999);  check("one_playing_load1", {31'd0, playing}, 32'd1);
    wait_cyc(1);    check("one_playing_end", {31'd0, playing}, 32'd0);

    wr_reg(32'h04, 32'd0);
    wr_reg(32'h08, 32'h0010_0100);
    wr_reg(32'h08, 32'h0020_0200);
    wr_reg(32'h08, 32'h0000_0000);
    wr_reg(32'h00, 32'd4);
    rd_reg(32'h00, d);  check("ctrl_loop_rd", d, 32'd4);
    wr_reg(32'h00, 32'd5);
    wait_cyc(500);  check("loop_n0", freq_out, 32'h100);
    wait_cyc(1000); check("loop_gap0", freq_out, 32'd0);
    wait_cyc(1500); check("loop_n1", freq_out, 32'h200);
    wait_cyc(1500); check("loop_gap1", freq_out, 32'd0);
    wait_cyc(1000); check("loop_n0_again", freq_out, 32'h100);
    wr_reg(32'h00, 32'd2);
    check("stop_playing", {31'd0, playing}, 32'd0);
    wait_cyc(1);    check("stop_freq", freq_out, 32'd0);

    wr_reg(32'h04, 32'd0);
    for (int i = 0; i < 16; i++) begin
      wr_reg(32'h08, 32'h0010_0000 | 32'(i + 1));
    end
    rd_reg(32'h04, d);  check("widx_wrap", d, 32'd0);
    wr_reg(32'h08, 32'h0010_0001);
    rd_reg(32'h04, d);  check("widx_after_wrap", d, 32'd1);
    wr_reg(32'h00, 32'd1);
    wait_cyc(500);      check("fill_n0", freq_out, 32'd1);
    wait_cyc(14007);    check("fill_n7", freq_out, 32'd8);
    rd_reg(32'h0C, d);  check("fill_status", d, 32'h710);
    wait_cyc(16007);    check("fill_n15", freq_out, 32'd16);
    wait_cyc(1500);     check("fill_playing_last", {31'd0, playing}, 32'd1);
    wait_cyc(1);        check("fill_idle", {31'd0, playing}, 32'd0);

    wr_reg(32'h04, 32'd0);
    wr_reg(32'h08, 32'h0050_0300);
    wr_reg(32'h08, 32'h0000_0000);
    wr_reg(32'h00, 32'd1);
    wait_cyc(2000); check("pause_before", freq_out, 32'h300);
    @(negedge clk); buttons_in = 4'b0010; @(posedge clk); #1;
    check("pause_d4", freq_out, 32'd1700);
    wait_cyc(999);  check("pause_d4_held", freq_out, 32'd1700);
    wait_cyc(1000);
    @(negedge clk); buttons_in = 4'b0000; @(posedge clk); #1;
    check("pause_resume", freq_out, 32'h300);
    wait_cyc(3000); check("pause_note_last", freq_out, 32'h300);
    wait_cyc(1);    check("pause_note_end", freq_out, 32'd0);
    k = 0;
    while (playing && k < 3000) begin
      wait_cyc(1);
      k++;
    end
    check("pause_reaches_idle", {31'd0, playing}, 32'd0);

    wr_reg(32'h04, 32'd0);
    wr_reg(32'h08, 32'h0000_0000);
    wr_reg(32'h00, 32'd5);
    check("empty_playing", {31'd0, playing}, 32'd1);
    check("empty_freq0", freq_out, 32'd0);
    wait_cyc(1);    check("empty_idle", {31'd0, playing}, 32'd0);
    check("empty_freq1", freq_out, 32'd0);
    wait_cyc(2);    check("empty_still_idle", {31'd0, playing}, 32'd0);

    wr_reg(32'h00, 32'd3);
    check("startstop_idle", {31'd0, playing}, 32'd0);
    wait_cyc(2);    check("startstop_still_idle", {31'd0, playing}, 32'd0);

    wr_reg(32'h04, 32'd0);
    wr_reg(32'h08, 32'h0010_0123);
    wr_reg(32'h08, 32'h0000_0000);
    wr_reg(32'h00, 32'd5);
    wait_cyc(300);  check("arst_before", freq_out, 32'h123);
    #2 reset = 1'b1;
    #1;
    check("arst_freq", freq_out, 32'd0);
    check("arst_playing", {31'd0, playing}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rd_reg(32'h00, d);  check("arst_ctrl", d, 32'd0);
    rd_reg(32'h04, d);  check("arst_widx", d, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/keyboard_note_sequencer.md
# keyboard_note_sequencer

Bus-programmable melody sequencer and tone arbiter for the keyboard/PWM sound path. It stores a short note list written by the SoC, plays it back with millisecond-resolution durations and inter-note gaps, and arbitrates between sequenced playback and the four debounced keyboard buttons. Its output is the half-period count that drives the square-wave PWM generator, which it sits directly in front of.

## Interface
- CLK_HZ, 25_000_000, system clock frequency; sets the ms tick and the button note table.
- DEPTH, 16, note-list entries; power of two, 2..16.
- GAP_MS, 10, silence between consecutive notes in ms; 0 means no gap.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- d_in  in  32  bus write data.
- cs  in  1  block select.
- addr  in  32  byte address; only addr[4:0] decoded.
- rd  in  1  read strobe.
- wr  in  1  write strobe.
- d_out  out  32  registered read data; 0 when not reading.
- buttons_in  in  4  debounced keyboard buttons, active high.
- freq_out  out  32  registered half-period count to the PWM generator; 0 = silence.
- playing  out  1  high while the sequencer is not IDLE.

## Operation
- Register map, addr[4:0]:
  - 0x00 CTRL. Write: bit0 START, bit1 STOP, bit2 LOOP (stored). Read: {29'b0, loop, 1'b0, playing}.
  - 0x04 WIDX. Write: note write index = d_in[3:0] mod DEPTH. Read: {28'b0, widx}.
  - 0x08 NOTE. Write: mem[widx] <= d_in, then widx <= widx+1, wrapping DEPTH-1 -> 0. Read: mem[widx].
  - 0x0C STATUS. Read: {20'b0, cur_idx[3:0], 3'b0, playing, buttons_in}.
  - Unmapped reads return 0. Unmapped writes are ignored.
- Note entry: [19:0] half-period count, where 0 = rest. [31:20] duration in ms; duration 0 = end-of-list marker.
- ms tick: a prescaler counts 0..CLK_HZ/1000-1 and pulses at the terminal count. It is cleared on every entry to PLAY or GAP.
- FSM states: IDLE, LOAD, PLAY, GAP.
  - IDLE: START -> LOAD with cur_idx <= 0.
  - LOAD: read mem[cur_idx].
    - If the duration is 0: when LOOP=1 and cur_idx≠0, go to LOAD with cur_idx <= 0; otherwise go to IDLE. This prevents an endless loop on an empty list.
    - Otherwise: cur_freq <= entry[19:0], dur_cnt <= entry[31:20], go to PLAY.
  - PLAY: dur_cnt decrements on each tick. On the tick where dur_cnt = 1, go to GAP with gap_cnt <= GAP_MS; if GAP_MS = 0, advance directly instead.
  - GAP: gap_cnt decrements on each tick. At 1, advance.
  - Advance: if cur_idx = DEPTH-1, go to LOAD with cur_idx 0 when LOOP=1, else go to IDLE. Otherwise cur_idx+1 and go to LOAD.
- STOP from any state -> IDLE on the next edge. START and STOP in the same write: STOP wins.
- START while not IDLE restarts from entry 0 via LOAD.
- Arbitration:
  - Any button high overrides the sequencer. Fixed priority is bit0 > bit1 > bit2 > bit3.
  - Button notes are C4/D4/E4/F4 = CLK_HZ/(2*262), /(2*294), /(2*330), /(2*349).
  - While any button is high, the ms prescaler and dur_cnt/gap_cnt freeze, so the sequence pauses and resumes where it left off.
  - Sequencer output is cur_freq in PLAY and 0 in all other states.
- Note memory may be written during playback. A change takes effect when that entry is next loaded.

## Timing
- Reset values: d_out=0, freq_out=0, playing=0, state=IDLE, loop=0, widx=0, cur_idx=0, all counters=0. Memory contents are not reset.
- Read latency is 1 cycle: d_out is valid the cycle after cs&rd and returns to 0 the following cycle unless reads continue.
- Write of START at edge N: LOAD in cycle N+1, PLAY from edge N+2, freq_out = note from edge N+3. playing rises at edge N+1.
- A note with duration D lasts exactly D ticks in PLAY when no button is pressed. The first tick comes CLK_HZ/1000 cycles after PLAY entry.
- Button change at edge N: freq_out updates at edge N+1.
- STOP at edge N: state is IDLE and playing=0 after edge N+1; freq_out=0 after edge N+2 unless a button is held.
- Reset asserted mid-note: all outputs go to their reset values immediately (asynchronous).

## Test plan
Benches use CLK_HZ=1_000_000 and GAP_MS=1.
- Reset, then read 0x00/0x0C -> 0. Press button 2 alone -> freq_out=1515 one cycle later. Press buttons 0 and 3 together -> 1908.
- Write WIDX=0, NOTE=0x0030_03E8, NOTE=0x0000_0000, then START -> playing at +1 cycle. freq_out=1000 from +3 cycles, held for 3000 cycles, then 0 for 1000 cycles, then playing=0.
- LOOP=1 with a 2-note list (durations 1 and 2 ms, 0x100/0x200) -> pattern 0x100, gap, 0x200, gap, repeating. STOP mid-note -> freq_out=0 within 2 cycles.
- Fill all 16 entries with duration 1 and no end marker, LOOP=0 -> 16 notes play, then IDLE. NOTE writes beyond entry 15 wrap widx to 0, checked via a 0x04 read.
- Play a 5 ms note, hold button 1 for 2000 cycles mid-note -> freq_out=1700 while held, and the note total including the pause is 7000 cycles.
- Empty list (entry 0 duration 0) with LOOP=1, then START -> playing high exactly 1 cycle, freq_out stays 0. START and STOP in the same write -> remains IDLE.
